// File: rtl/axi_rd_sched.sv
// rtl/axi_rd_sched.sv - AR-channel scheduler for i-cache/d-cache reads with R-beat routing by ID
// Optional feature: define RD_SCHED_RR_EN for round-robin arbitration (default is d-cache priority).
module axi_rd_sched #(
  parameter int         MAX_OUTST = 2,
  parameter logic [3:0] ID_I      = 4'd0,
  parameter logic [3:0] ID_D      = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req_i,
  input  logic [2:0]  rd_type_i,
  input  logic [31:0] rd_addr_i,
  output logic        rd_rdy_i,
  input  logic        rd_req_d,
  input  logic [2:0]  rd_type_d,
  input  logic [31:0] rd_addr_d,
  output logic        rd_rdy_d,
  input  logic        wr_busy,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic        rlast,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  output logic        rready,
  output logic        ret_valid_i,
  output logic        ret_valid_d,
  output logic        ret_last_i,
  output logic        ret_last_d,
  output logic [31:0] ret_data
);

  localparam logic [2:0] MAX_C = 3'(MAX_OUTST);

  typedef enum logic {IDLE, ADDR} state_t;
  state_t state, state_nxt;

  logic [2:0] cnt_i, cnt_d;
  logic       own_d;
  logic       elig_i, elig_d, gnt_i, gnt_d;
  logic       inc_i, inc_d, dec_i, dec_d;
  logic       ar_hs;

  assign elig_i = rd_req_i && (cnt_i < MAX_C);
  assign elig_d = rd_req_d && (cnt_d < MAX_C) && !wr_busy;

`ifdef RD_SCHED_RR_EN
  logic pri_d;
`endif

  always_comb begin
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!reset) begin
`ifdef RD_SCHED_RR_EN
          if (elig_d && (!elig_i || pri_d)) gnt_d = 1'b1;
          else if (elig_i)                  gnt_i = 1'b1;
`else
          if (elig_d)      gnt_d = 1'b1;
          else if (elig_i) gnt_i = 1'b1;
`endif
        end
        if (gnt_i || gnt_d) state_nxt = ADDR;
      end
      ADDR: if (arready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_rdy_i = gnt_i;
  assign rd_rdy_d = gnt_d;
  assign arvalid  = (state == ADDR);
  assign arsize   = 3'b010;
  assign ar_hs    = arvalid && arready;

  // Decrement is keyed on the exact source ID; a stray completion at zero is dropped.
  assign inc_i = ar_hs && !own_d;
  assign inc_d = ar_hs && own_d;
  assign dec_i = rvalid && rready && rlast && (rid == ID_I) && (cnt_i != 3'd0);
  assign dec_d = rvalid && rready && rlast && (rid == ID_D) && (cnt_d != 3'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      arid   <= 4'd0;
      araddr <= 32'd0;
      arlen  <= 8'd0;
      own_d  <= 1'b0;
      cnt_i  <= 3'd0;
      cnt_d  <= 3'd0;
    end else begin
      state <= state_nxt;
      if (gnt_d) begin
        arid   <= ID_D;
        araddr <= rd_addr_d;
        arlen  <= (rd_type_d == 3'b100) ? 8'd3 : 8'd0;
        own_d  <= 1'b1;
      end else if (gnt_i) begin
        arid   <= ID_I;
        araddr <= rd_addr_i;
        arlen  <= (rd_type_i == 3'b100) ? 8'd3 : 8'd0;
        own_d  <= 1'b0;
      end
      case ({inc_i, dec_i})
        2'b10:   cnt_i <= cnt_i + 3'd1;
        2'b01:   cnt_i <= cnt_i - 3'd1;
        default: cnt_i <= cnt_i;
      endcase
      case ({inc_d, dec_d})
        2'b10:   cnt_d <= cnt_d + 3'd1;
        2'b01:   cnt_d <= cnt_d - 3'd1;
        default: cnt_d <= cnt_d;
      endcase
    end
  end

`ifdef RD_SCHED_RR_EN
  // Pointer names the source that wins the next tie; it flips away from each winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      pri_d <= 1'b1;
    else if (gnt_d) pri_d <= 1'b0;
    else if (gnt_i) pri_d <= 1'b1;
  end
`endif

  assign rready      = !reset;
  assign ret_valid_d = rvalid && rready && (rid == ID_D);
  assign ret_valid_i = rvalid && rready && (rid != ID_D);
  assign ret_last_d  = ret_valid_d && rlast;
  assign ret_last_i  = ret_valid_i && rlast;
  assign ret_data    = rdata;

endmodule

// File: doc/axi_rd_sched.md
# axi_rd_sched

Read-address scheduler between the i-cache and d-cache read ports and the single AXI AR channel. Each cycle it picks one requester under a fixed or round-robin policy, latches its request and drives the AR channel. It enforces a per-source outstanding-transaction limit and a read-after-write gate for d-cache reads. It routes R-channel beats back to the owning cache by ID. It sits inside the AXI bridge, in place of the combinational AR priority mux.

## Interface
Parameters:
- MAX_OUTST, 2: maximum outstanding AR transactions per source (1..7).
- ID_I, 4'd0: arid used for i-cache reads.
- ID_D, 4'd1: arid used for d-cache reads.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_req_i / rd_req_d  in  1  cache read request.
- rd_type_i / rd_type_d  in  3  3'b100 = 4-beat line fill; any other value = single beat.
- rd_addr_i / rd_addr_d  in  32  read address.
- rd_rdy_i / rd_rdy_d  out  1  request accepted this cycle.
- wr_busy  in  1  one or more d-cache writes have no B response yet.
- arid  out  4  AR ID.
- araddr  out  32  AR address.
- arlen  out  8  AR burst length.
- arsize  out  3  AR transfer size.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  4  R ID.
- rlast  in  1  R last beat.
- rvalid  in  1  R valid.
- rdata  in  32  R data.
- rready  out  1  R ready.
- ret_valid_i / ret_valid_d  out  1  routed R beat valid.
- ret_last_i / ret_last_d  out  1  routed R last beat.
- ret_data  out  32  routed R data, shared by both caches.

## Operation
- FSM with two states: IDLE and ADDR.
- IDLE:
  - Eligible sources:
    - i-cache: rd_req_i && cnt_i < MAX_OUTST.
    - d-cache: rd_req_d && cnt_d < MAX_OUTST && !wr_busy.
  - With no eligible source, stay in IDLE.
  - With an eligible source, grant exactly one of them. rd_rdy_x is asserted combinationally for the granted source only.
  - On grant, latch arid (ID_I or ID_D), araddr and arlen, then move to ADDR.
  - arlen = 8'd3 when rd_type == 3'b100, otherwise 8'd0.
  - arsize is always 3'b010.
- ADDR:
  - arvalid = 1 and the AR fields are held stable.
  - On arvalid && arready, increment the granted source's counter and return to IDLE.
  - rd_rdy_i and rd_rdy_d are both 0 in ADDR.
- Outstanding counters cnt_i and cnt_d, 3 bits each:
  - Increment on the AR handshake for that source.
  - Decrement on rvalid && rready && rlast with rid equal to that source's ID.
  - Increment and decrement in the same cycle leave the counter unchanged.
  - A counter never exceeds MAX_OUTST and never goes below 0. A decrement arriving at 0 is ignored.
- R routing:
  - rready = 1 whenever reset is low.
  - ret_valid_d = rvalid && rid == ID_D.
  - ret_valid_i = rvalid && rid != ID_D.
  - ret_last_x = ret_valid_x && rlast.
  - ret_data = rdata.
- Reset mid-operation:
  - All state clears immediately and any pending AR is dropped.
  - Beats arriving while reset is high are not routed.

## Timing
- Reset values:
  - arvalid = 0, arid = 0, araddr = 0, arlen = 0, arsize = 3'b010.
  - rready = 0.
  - rd_rdy_i = rd_rdy_d = 0.
  - ret_valid_i = ret_valid_d = 0, ret_last_i = ret_last_d = 0.
  - cnt_i = cnt_d = 0, FSM = IDLE, round-robin pointer = d-cache.
- rd_rdy in cycle N makes arvalid 1 from cycle N+1. With arready already high, the AR handshake completes in cycle N+1.
- Best-case throughput is one AR every 2 cycles.
- AR fields do not change while arvalid=1 && arready=0.
- R routing is purely combinational, with zero latency from rvalid to ret_valid.
- wr_busy is sampled only in IDLE. Its rising edge while in ADDR does not cancel an already-latched d-cache read.

## Configuration
- RD_SCHED_RR_EN defined:
  - Round-robin arbitration. When both sources are eligible, grant the source that was not granted last.
  - The pointer updates on every grant.
- RD_SCHED_RR_EN undefined:
  - Fixed priority, d-cache over i-cache.
  - No pointer register exists.

## Test plan
- Fixed priority: rd_req_i=rd_req_d=1 in the same cycle, arready=1 -> rd_rdy_d=1 first.
  - arid=1, araddr=rd_addr_d, arlen=3 for rd_type_d=3'b100.
  - The i-cache is granted 2 cycles later with arid=0.
- Round-robin (RD_SCHED_RR_EN): both requesting continuously.
  - Grants alternate d, i, d, i.
  - Each arvalid is separated by exactly 2 cycles.
- Backpressure: hold arready=0 for 5 cycles after a grant.
  - arvalid stays 1 and araddr stays fixed.
  - rd_rdy_x stays 0.
  - The handshake completes on the cycle arready=1.
- Outstanding limit, MAX_OUTST=2: three i-cache line requests with no R traffic.
  - The third request waits with rd_rdy_i=0.
  - rvalid=1, rlast=1, rid=0 -> the third request is granted in the next IDLE cycle.
- RAW gate: wr_busy=1 with rd_req_d=1 -> rd_rdy_d stays 0.
  - An i-cache request is still granted.
  - Drop wr_busy -> the d-cache read is granted the same cycle.
- R routing and reset:
  - 4-beat burst on rid=1 -> ret_valid_d=1 on 4 beats and ret_last_d=1 on the 4th; ret_valid_i stays 0.
  - Assert reset during ADDR -> arvalid=0 and both counters=0 immediately.
